// File: rtl/pixel_readout.sv
// Row capture buffer and pixel serializer: latches one digitized row from the
// column bus and streams it out pixel by pixel with coordinates and frame markers.
module pixel_readout #(
   parameter int PIXEL_ARRAY_HEIGHT = 2,
   parameter int PIXEL_ARRAY_WIDTH  = 2,
   parameter int PIXEL_BITS         = 8,
   localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
   localparam int COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
   input  logic                                  CLK,
   input  logic                                  RESET,
   input  logic [PIXEL_ARRAY_HEIGHT-1:0]         SENSOR_ROW_SELECT,
   input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] PIXEL_DATA,
   output logic                                  OUT_VALID,
   input  logic                                  OUT_READY,
   output logic [PIXEL_BITS-1:0]                 OUT_DATA,
   output logic [ROW_W-1:0]                      OUT_ROW,
   output logic [COL_W-1:0]                      OUT_COL,
   output logic                                  OUT_FIRST,
   output logic                                  OUT_LAST,
   output logic                                  OVERFLOW,
   output logic                                  SEL_ERROR
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIXEL_ARRAY_WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t                                  state;
   logic [PIXEL_ARRAY_HEIGHT-1:0]           prev_sel;
   logic                                    captured;
   logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_buf;
   logic [ROW_W-1:0]                        row_idx;
   logic [COL_W-1:0]                        col_idx;
   logic                                    overflow_flag;
   logic                                    sel_error_flag;

   logic multi_sel;
   logic one_hot;
   logic capture;
   logic transfer;
   logic final_transfer;

   function automatic logic [ROW_W-1:0] encode_row(input logic [PIXEL_ARRAY_HEIGHT-1:0] sel);
      logic [ROW_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
         if (sel[i]) idx = ROW_W'(i);
      end
      return idx;
   endfunction

   // A select must be seen identical on two edges so the column bus has a cycle to settle.
   assign multi_sel      = |(SENSOR_ROW_SELECT & (SENSOR_ROW_SELECT - 1'b1));
   assign one_hot        = (SENSOR_ROW_SELECT != '0) && !multi_sel;
   assign capture        = one_hot && (SENSOR_ROW_SELECT == prev_sel) && !captured;
   assign transfer       = OUT_VALID && OUT_READY;
   assign final_transfer = transfer && (col_idx == LAST_COL);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state          <= IDLE;
         prev_sel       <= '0;
         captured       <= 1'b0;
         row_buf        <= '0;
         row_idx        <= '0;
         col_idx        <= '0;
         overflow_flag  <= 1'b0;
         sel_error_flag <= 1'b0;
      end else begin
         prev_sel <= SENSOR_ROW_SELECT;

         // A dropped row still consumes this assertion, so overflow fires once per row.
         if (capture) begin
            captured <= 1'b1;
         end else if ((SENSOR_ROW_SELECT != prev_sel) || (SENSOR_ROW_SELECT == '0)) begin
            captured <= 1'b0;
         end

         if (multi_sel) begin
            sel_error_flag <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (capture) begin
                  row_buf <= PIXEL_DATA;
                  row_idx <= encode_row(SENSOR_ROW_SELECT);
                  col_idx <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (final_transfer) begin
                  if (capture) begin
                     row_buf <= PIXEL_DATA;
                     row_idx <= encode_row(SENSOR_ROW_SELECT);
                     col_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  if (transfer) begin
                     col_idx <= col_idx + 1'b1;
                  end
                  if (capture) begin
                     overflow_flag <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign OUT_VALID = (state == SHIFT);
   assign OUT_DATA  = OUT_VALID ? row_buf[int'(col_idx)*PIXEL_BITS +: PIXEL_BITS] : '0;
   assign OUT_ROW   = OUT_VALID ? row_idx : '0;
   assign OUT_COL   = OUT_VALID ? col_idx : '0;
   assign OUT_FIRST = OUT_VALID && (row_idx == '0) && (col_idx == '0);
   assign OUT_LAST  = OUT_VALID && (row_idx == LAST_ROW) && (col_idx == LAST_COL);
   assign OVERFLOW  = overflow_flag;
   assign SEL_ERROR = sel_error_flag;

endmodule

// File: tb/tb_pixel_readout.sv
// Scoreboard bench for pixel_readout at W=2, H=2, B=8: expected pixels are queued
// when a row is driven and compared as the DUT hands each pixel over.
module tb_pixel_readout;

   logic        CLK;
   logic        RESET;
   logic [1:0]  SENSOR_ROW_SELECT;
   logic [15:0] PIXEL_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [7:0]  OUT_DATA;
   logic [0:0]  OUT_ROW;
   logic [0:0]  OUT_COL;
   logic        OUT_FIRST;
   logic        OUT_LAST;
   logic        OVERFLOW;
   logic        SEL_ERROR;

   typedef struct {
      logic [7:0] data;
      logic       row;
      logic       col;
      logic       first;
      logic       last;
   } exp_t;

   exp_t sb[$];
   int   assert_count = 0;
   int   fail_count   = 0;

   pixel_readout #(
      .PIXEL_ARRAY_HEIGHT(2),
      .PIXEL_ARRAY_WIDTH (2),
      .PIXEL_BITS        (8)
   ) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .SENSOR_ROW_SELECT(SENSOR_ROW_SELECT),
      .PIXEL_DATA       (PIXEL_DATA),
      .OUT_VALID        (OUT_VALID),
      .OUT_READY        (OUT_READY),
      .OUT_DATA         (OUT_DATA),
      .OUT_ROW          (OUT_ROW),
      .OUT_COL          (OUT_COL),
      .OUT_FIRST        (OUT_FIRST),
      .OUT_LAST         (OUT_LAST),
      .OVERFLOW         (OVERFLOW),
      .SEL_ERROR        (SEL_ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_row(input logic row, input logic [15:0] data);
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e.data  = data[c*8 +: 8];
         e.row   = row;
         e.col   = c[0];
         e.first = (row == 1'b0) && (c == 0);
         e.last  = (row == 1'b1) && (c == 1);
         sb.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data, input int cycles);
      SENSOR_ROW_SELECT = sel;
      PIXEL_DATA        = data;
      repeat (cycles) tick();
      SENSOR_ROW_SELECT = 2'b00;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      checkOutput({tag, "_valid"}, 32'(OUT_VALID), 0);
      checkOutput({tag, "_data"},  32'(OUT_DATA),  0);
      checkOutput({tag, "_row"},   32'(OUT_ROW),   0);
      checkOutput({tag, "_col"},   32'(OUT_COL),   0);
      checkOutput({tag, "_first"}, 32'(OUT_FIRST), 0);
      checkOutput({tag, "_last"},  32'(OUT_LAST),  0);
      checkOutput({tag, "_ovf"},   32'(OVERFLOW),  0);
      checkOutput({tag, "_selerr"},32'(SEL_ERROR), 0);
   endtask

   // Every handshake pops one expected pixel; a handshake with nothing queued is an error.
   always @(negedge CLK) begin
      if (!RESET && OUT_VALID && OUT_READY) begin
         if (sb.size() == 0) begin
            checkOutput("sb_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_data",  32'(OUT_DATA),  32'(e.data));
            checkOutput("sb_row",   32'(OUT_ROW),   32'(e.row));
            checkOutput("sb_col",   32'(OUT_COL),   32'(e.col));
            checkOutput("sb_first", 32'(OUT_FIRST), 32'(e.first));
            checkOutput("sb_last",  32'(OUT_LAST),  32'(e.last));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RESET             = 1'b1;
      SENSOR_ROW_SELECT = 2'b00;
      PIXEL_DATA        = 16'h0000;
      OUT_READY         = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      RESET = 1'b0;
      tick();

      $display("[TB] single row, latency and single capture");
      push_row(1'b0, 16'hB2A1);
      SENSOR_ROW_SELECT = 2'b01;
      PIXEL_DATA        = 16'hB2A1;
      tick();
      checkOutput("lat_t1_valid", 32'(OUT_VALID), 0);
      tick();
      checkOutput("lat_t2_valid", 32'(OUT_VALID), 1);
      checkOutput("lat_t2_data",  32'(OUT_DATA),  32'hA1);
      checkOutput("lat_t2_first", 32'(OUT_FIRST), 1);
      tick();
      SENSOR_ROW_SELECT = 2'b00;
      checkOutput("t3_data", 32'(OUT_DATA), 32'hB2);
      checkOutput("t3_col",  32'(OUT_COL),  1);
      tick();
      tick();
      checkOutput("single_capture_valid", 32'(OUT_VALID), 0);
      tick();

      $display("[TB] full frame");
      push_row(1'b0, 16'h2211);
      applyStimulus(2'b01, 16'h2211, 2);
      repeat (3) tick();
      push_row(1'b1, 16'h4433);
      applyStimulus(2'b10, 16'h4433, 2);
      repeat (3) tick();
      checkOutput("frame_ovf",    32'(OVERFLOW),  0);
      checkOutput("frame_selerr", 32'(SEL_ERROR), 0);
      checkOutput("frame_idle",   32'(OUT_VALID), 0);

      $display("[TB] backpressure");
      OUT_READY = 1'b0;
      push_row(1'b0, 16'hB2A1);
      applyStimulus(2'b01, 16'hB2A1, 2);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_valid", 32'(OUT_VALID), 1);
         checkOutput("stall_data",  32'(OUT_DATA),  32'hA1);
         checkOutput("stall_col",   32'(OUT_COL),   0);
         tick();
      end
      OUT_READY = 1'b1;
      repeat (4) tick();

      $display("[TB] back-to-back rows");
      push_row(1'b0, 16'h2211);
      push_row(1'b1, 16'h4433);
      applyStimulus(2'b01, 16'h2211, 2);
      applyStimulus(2'b10, 16'h4433, 2);
      checkOutput("b2b_valid", 32'(OUT_VALID), 1);
      checkOutput("b2b_row",   32'(OUT_ROW),   1);
      checkOutput("b2b_col",   32'(OUT_COL),   0);
      checkOutput("b2b_data",  32'(OUT_DATA),  32'h33);
      checkOutput("b2b_ovf",   32'(OVERFLOW),  0);
      repeat (4) tick();

      $display("[TB] overflow");
      OUT_READY = 1'b0;
      push_row(1'b0, 16'h2211);
      applyStimulus(2'b01, 16'h2211, 2);
      checkOutput("ovf_pre", 32'(OVERFLOW), 0);
      applyStimulus(2'b10, 16'h4433, 2);
      checkOutput("ovf_flag", 32'(OVERFLOW), 1);
      checkOutput("ovf_data", 32'(OUT_DATA), 32'h11);
      checkOutput("ovf_row",  32'(OUT_ROW),  0);
      OUT_READY = 1'b1;
      repeat (4) tick();
      checkOutput("ovf_sticky", 32'(OVERFLOW), 1);
      checkOutput("ovf_idle",   32'(OUT_VALID), 0);

      $display("[TB] select error and reset");
      SENSOR_ROW_SELECT = 2'b11;
      PIXEL_DATA        = 16'h5566;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("selerr_novalid", 32'(OUT_VALID), 0);
      end
      SENSOR_ROW_SELECT = 2'b00;
      checkOutput("selerr_flag", 32'(SEL_ERROR), 1);
      OUT_READY = 1'b0;
      applyStimulus(2'b01, 16'h7788, 2);
      checkOutput("midrow_valid", 32'(OUT_VALID), 1);
      do_reset();
      check_idle_outputs("midrow_reset");

      $display("[TB] select held through reset");
      SENSOR_ROW_SELECT = 2'b01;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      checkOutput("held_c0_valid", 32'(OUT_VALID), 0);
      tick();
      checkOutput("held_c1_valid", 32'(OUT_VALID), 0);
      tick();
      checkOutput("held_c2_valid", 32'(OUT_VALID), 1);
      checkOutput("held_c2_data",  32'(OUT_DATA),  32'h88);
      SENSOR_ROW_SELECT = 2'b00;
      checkOutput("held_c2_data_sel0", 32'(OUT_DATA), 32'h88);
      do_reset();
      OUT_READY = 1'b1;
      tick();

      checkOutput("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Row readout and serializer on the far side of the sensor control sequencer. While `SENSOR_ROW_SELECT` holds a row active, it captures that row's digitized pixel values from the shared column bus into a one-row buffer. It then streams the values out one pixel per transfer over a valid/ready interface, with row/column coordinates and frame markers attached. Malformed row selects and rows that arrive while the buffer is still draining are flagged through sticky error outputs.

## Interface
Parameters:
- `PIXEL_ARRAY_HEIGHT`, default 2: number of rows, and width of the row-select vector.
- `PIXEL_ARRAY_WIDTH`, default 2: pixels per row.
- `PIXEL_BITS`, default 8: bits per pixel value.

Ports:
- `CLK`  in  1  single clock for all state.
- `RESET`  in  1  synchronous, active-high. Sampled on the rising edge of `CLK`.
- `SENSOR_ROW_SELECT`  in  `PIXEL_ARRAY_HEIGHT`  one-hot row select from the sequencer. All zeros means no row.
- `PIXEL_DATA`  in  `PIXEL_ARRAY_WIDTH*PIXEL_BITS`  column bus. Column c occupies bits `[c*PIXEL_BITS +: PIXEL_BITS]`.
- `OUT_VALID`  out  1  pixel available.
- `OUT_READY`  in  1  downstream accepts.
- `OUT_DATA`  out  `PIXEL_BITS`  pixel value.
- `OUT_ROW`  out  `$clog2(PIXEL_ARRAY_HEIGHT)` (minimum 1)  index of the captured row.
- `OUT_COL`  out  `$clog2(PIXEL_ARRAY_WIDTH)` (minimum 1)  column index.
- `OUT_FIRST`  out  1  high on row 0, column 0 (start of frame).
- `OUT_LAST`  out  1  high on the last row, last column (end of frame).
- `OVERFLOW`  out  1  sticky: a row was dropped because the buffer was busy.
- `SEL_ERROR`  out  1  sticky: the row select had more than one bit set.

## Operation
- Capture detector: registers the previous `SENSOR_ROW_SELECT`.
  - Capture event: the current select is one-hot, equals the previous select, and no capture has yet occurred for this assertion.
  - In other words, a select must hold for at least 2 cycles. The bus is sampled in the 2nd cycle, which gives it one cycle to settle.
  - One capture per assertion. Re-arm only when the select changes or goes to zero.
- Select with 2 or more bits set: no capture, and `SEL_ERROR` is set.
- Capture event actions:
  - Latch `PIXEL_DATA` into the row buffer.
  - Latch the encoded row index.
  - Set the column counter to 0.
- State machine, states IDLE and SHIFT.
  - IDLE → SHIFT on a capture event.
  - SHIFT: `OUT_VALID`=1. A transfer is `OUT_VALID && OUT_READY`.
  - On a transfer with column < W-1: column increments.
  - On a transfer at column W-1: go to IDLE, unless a capture event occurs in the same cycle. In that case the new row is accepted, the state stays SHIFT and the column goes to 0.
  - Capture event in SHIFT without a final transfer: the new row is dropped, the buffer is untouched, and `OVERFLOW` is set.
- Output fields:
  - `OUT_DATA` is the buffer slice for the current column.
  - `OUT_FIRST` = (row==0 && col==0).
  - `OUT_LAST` = (row==H-1 && col==W-1).
  - All output fields are gated to 0 when `OUT_VALID`=0.
- Sticky flags clear only on `RESET`.

## Timing
- Reset values:
  - `OUT_VALID`, `OUT_DATA`, `OUT_ROW`, `OUT_COL`, `OUT_FIRST`, `OUT_LAST`, `OVERFLOW`, `SEL_ERROR`: all 0.
  - State IDLE, capture detector disarmed, previous-select register 0.
- Latency: select asserted in cycles t0 and t1 → capture at the edge ending t1 → `OUT_VALID`=1 in t2.
- `OUT_READY` held high: W transfers in consecutive cycles. `OUT_VALID` drops the cycle after the last transfer, unless a back-to-back capture occurred.
- Stall: while `OUT_VALID && !OUT_READY`, `OUT_DATA`, `OUT_ROW`, `OUT_COL`, `OUT_FIRST` and `OUT_LAST` are held stable.
- `OVERFLOW` and `SEL_ERROR` rise in the cycle after the triggering edge.
- `RESET` asserted mid-row: the buffer is abandoned, and the next cycle shows all outputs at their reset values.
- A select that is still held after reset counts from cycle 1 again. It needs to be seen stable for one more edge before capture.
- Row select dropping to 0 mid-stream does not affect a row already captured.

## Test plan
With W=2, H=2, B=8 throughout:
- Select 2'b01 held 3 cycles, `PIXEL_DATA`=16'hB2A1, `OUT_READY`=1 → `OUT_VALID` from the 3rd cycle.
  - First output: `OUT_DATA` 8'hA1, col 0, row 0, `OUT_FIRST`=1.
  - Next cycle: 8'hB2, col 1.
  - Only one capture for the held select.
- Full frame: row 0 with 16'h2211, then row 1 with 16'h4433, `OUT_READY`=1 → outputs 11, 22, 33, 44. `OUT_LAST`=1 only on 8'h44. No flags set.
- Backpressure: `OUT_READY`=0 for 5 cycles after valid → `OUT_DATA` stays 8'hA1 with col 0 for all 5 cycles. On release, the sequence resumes at 8'hB2.
- Overflow: row 0 captured with `OUT_READY`=0, then row 1 select held 2 cycles → `OVERFLOW`=1. The stream stays on row 0 data.
- Back-to-back: row 1 capture coincides with the final transfer of row 0 → no overflow. `OUT_VALID` stays high, and the next output is row 1, col 0.
- Error/reset: select 2'b11 held 3 cycles → `SEL_ERROR`=1, no `OUT_VALID`. Then `RESET` for 1 cycle → all outputs 0 the next cycle.
